// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM arbiter: requester id type,
// size limits and the width of the optional statistics counters.
package bram_arb_pkg;

   localparam int NUM_REQ_MAX = 8;
   localparam int STAT_W      = 32;

   typedef logic [2:0] req_id_t;

   function automatic int unsigned popcount(input logic [NUM_REQ_MAX-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < NUM_REQ_MAX; i++) begin
         n += {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/bram_arbiter_bram.sv
// Simple dual-port RAM with a registered read address, so a read issued in the
// same cycle as a write to the same address sees the new data.
module BRAM_inst #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] rd_addr_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[write_addr] <= data_in;
      end
      rd_addr_reg <= read_addr;
   end

   assign data_out = mem[rd_addr_reg];

endmodule

// File: rtl/bram_arbiter_rr_arb.sv
// Round-robin arbiter: the search starts at ptr and wraps; the pointer moves
// to one past the winner on a grant and holds otherwise.
module rr_arb
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] cand,
   output logic [NUM_REQ-1:0] grant,
   output req_id_t            grant_id,
   output logic               grant_any
);

   req_id_t ptr_reg;

   // Scan from the farthest offset down so the nearest candidate to ptr wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_id  = '0;
      grant_any = 1'b0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = int'(ptr_reg) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (cand[idx]) begin
            grant_id  = req_id_t'(idx);
            grant_any = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
         assign grant[gi] = grant_any && (grant_id == req_id_t'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (grant_any) begin
         ptr_reg <= (grant_id == req_id_t'(NUM_REQ - 1)) ? '0 : grant_id + 3'd1;
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one simple dual-port BRAM among NUM_REQ requesters with independent
// round-robin arbiters on the write and read ports. Defining
// BRAM_ARB_STATS_EN adds per-requester grant counters and a conflict counter.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 3,
   parameter int NUM_REQ    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata
`ifdef BRAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     stat_wr_grants,
   output logic [NUM_REQ*STAT_W-1:0]     stat_rd_grants,
   output logic [STAT_W-1:0]             stat_conflicts
`endif
);

   logic [NUM_REQ-1:0]    wr_cand;
   logic [NUM_REQ-1:0]    rd_cand;
   logic [NUM_REQ-1:0]    wr_grant;
   logic [NUM_REQ-1:0]    rd_grant;
   req_id_t               wr_id;
   req_id_t               rd_id;
   logic                  wr_any;
   logic                  rd_any;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ_MAX];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ_MAX];

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] data_out;

   logic [ADDR_WIDTH-1:0] rd_addr_hold_reg;
   req_id_t               rd_owner_reg;
   logic                  rd_pend_reg;

   // Masking candidates with rst keeps req_ready low throughout reset.
   assign wr_cand = req_valid &  req_we & {NUM_REQ{~rst}};
   assign rd_cand = req_valid & ~req_we & {NUM_REQ{~rst}};

   // Unused slots are tied off so a 3-bit requester id always indexes in range.
   generate
      for (genvar gi = 0; gi < NUM_REQ_MAX; gi++) begin : g_unpack
         if (gi < NUM_REQ) begin : g_used
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_unused
            assign addr_arr[gi]  = '0;
            assign wdata_arr[gi] = '0;
         end
      end
   endgenerate

   rr_arb #(.NUM_REQ(NUM_REQ)) u_wr_arb (
      .clk       (clk),
      .rst       (rst),
      .cand      (wr_cand),
      .grant     (wr_grant),
      .grant_id  (wr_id),
      .grant_any (wr_any)
   );

   rr_arb #(.NUM_REQ(NUM_REQ)) u_rd_arb (
      .clk       (clk),
      .rst       (rst),
      .cand      (rd_cand),
      .grant     (rd_grant),
      .grant_id  (rd_id),
      .grant_any (rd_any)
   );

   assign req_ready  = wr_grant | rd_grant;
   assign wr_en      = wr_any;
   assign write_addr = addr_arr[wr_id];
   assign data_in    = wdata_arr[wr_id];
   assign read_addr  = rd_any ? addr_arr[rd_id] : rd_addr_hold_reg;

   BRAM_inst #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bram (
      .clk        (clk),
      .wr_en      (wr_en),
      .write_addr (write_addr),
      .data_in    (data_in),
      .read_addr  (read_addr),
      .data_out   (data_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_hold_reg <= '0;
         rd_owner_reg     <= '0;
         rd_pend_reg      <= 1'b0;
      end else begin
         rd_pend_reg <= rd_any;
         if (rd_any) begin
            rd_addr_hold_reg <= addr_arr[rd_id];
            rd_owner_reg     <= rd_id;
         end
      end
   end

   // Gating with rst drops a response whose cycle coincides with reset.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
         assign rsp_valid[gi] = rd_pend_reg && !rst && (rd_owner_reg == req_id_t'(gi));
      end
   endgenerate

   assign rsp_rdata = data_out;

`ifdef BRAM_ARB_STATS_EN
   logic [STAT_W-1:0] conflicts_reg;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
         logic [STAT_W-1:0] wr_cnt_reg;
         logic [STAT_W-1:0] rd_cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               wr_cnt_reg <= '0;
               rd_cnt_reg <= '0;
            end else begin
               if (wr_grant[gi]) begin
                  wr_cnt_reg <= wr_cnt_reg + 1'b1;
               end
               if (rd_grant[gi]) begin
                  rd_cnt_reg <= rd_cnt_reg + 1'b1;
               end
            end
         end

         assign stat_wr_grants[gi*STAT_W +: STAT_W] = wr_cnt_reg;
         assign stat_rd_grants[gi*STAT_W +: STAT_W] = rd_cnt_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         conflicts_reg <= '0;
      end else if ((popcount(NUM_REQ_MAX'(wr_cand)) > 1) ||
                   (popcount(NUM_REQ_MAX'(rd_cand)) > 1)) begin
         conflicts_reg <= conflicts_reg + 1'b1;
      end
   end

   assign stat_conflicts = conflicts_reg;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: stimulus pushes expected read responses into
// a scoreboard queue; a negedge monitor pops and checks them when due.
module tb_bram_arbiter;

   localparam int DW = 128;
   localparam int AW = 3;
   localparam int NR = 2;

   typedef struct {
      int         due;
      int         id;
      logic [DW-1:0] data;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;

   exp_t sb [$];
   int   cyc;
   int   n_cmp;
   int   n_bad;

   bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, sb_left=%0d", sb.size());
      $fatal(1, "watchdog");
   end

   // Monitor: each cycle rsp_valid must match the due scoreboard entry (or be 0).
   always @(negedge clk) begin
      logic [NR-1:0] exp_v;
      exp_t e;
      exp_v = '0;
      if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         exp_v[e.id] = 1'b1;
         n_cmp++;
         if (e.due != cyc || rsp_rdata !== e.data) begin
            n_bad++;
            $display("FAIL rsp_rdata cyc=%0d id=%0d got=%h want=%h due=%0d",
                     cyc, e.id, rsp_rdata, e.data, e.due);
         end else begin
            $display("rsp cyc=%0d id=%0d data=%h ok", cyc, e.id, rsp_rdata);
         end
      end
      n_cmp++;
      if (rsp_valid !== exp_v) begin
         n_bad++;
         $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, exp_v);
      end
   end

   task automatic drive(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   // Checks req_ready mid-cycle, queues a read response if one is expected,
   // then advances to just after the next rising edge.
   task automatic step(input string name, input logic [1:0] exp_ready,
                       input int rd_id, input logic [DW-1:0] rd_data);
      exp_t e;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== exp_ready) begin
         n_bad++;
         $display("FAIL %s cyc=%0d req_ready got=%b want=%b", name, cyc, req_ready, exp_ready);
      end else begin
         $display("txn %s cyc=%0d valid=%b we=%b ready=%b", name, cyc, req_valid, req_we, req_ready);
      end
      if (rd_id >= 0) begin
         e.due  = cyc + 1;
         e.id   = rd_id;
         e.data = rd_data;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      drive(2'b11, 2'b01, 1, 2, 128'h9, 0);
      step("reset_ready", 2'b00, -1, 0);
      rst = 1'b0;

      drive(2'b01, 2'b01, 3, 0, 128'h10, 0);   step("wr0_a3",     2'b01, -1, 0);
      drive(2'b01, 2'b00, 3, 0, 0, 0);         step("rd0_a3",     2'b01, 0, 128'h10);
      drive(2'b01, 2'b01, 1, 0, 128'hA, 0);    step("wr0_a1",     2'b01, -1, 0);
      drive(2'b10, 2'b10, 0, 2, 0, 128'hB);    step("wr1_a2",     2'b10, -1, 0);
      drive(2'b10, 2'b00, 0, 2, 0, 0);         step("rd1_a2",     2'b10, 1, 128'hB);

      drive(2'b11, 2'b00, 1, 2, 0, 0);
      step("rr_rd_a", 2'b01, 0, 128'hA);
      step("rr_rd_b", 2'b10, 1, 128'hB);
      step("rr_rd_c", 2'b01, 0, 128'hA);
      step("rr_rd_d", 2'b10, 1, 128'hB);

      drive(2'b11, 2'b01, 5, 5, 128'h55, 0);   step("wr0_rd1_a5", 2'b11, 1, 128'h55);
      drive(2'b10, 2'b10, 0, 7, 0, 128'h77);   step("wr1_a7",     2'b10, -1, 0);
      drive(2'b11, 2'b11, 0, 0, 128'h1, 128'h2); step("wr_both_a", 2'b01, -1, 0);
      drive(2'b10, 2'b10, 0, 0, 128'h1, 128'h2); step("wr_both_b", 2'b10, -1, 0);
      drive(2'b01, 2'b00, 0, 0, 0, 0);         step("rd0_a0",     2'b01, 0, 128'h2);

      drive(2'b01, 2'b01, 6, 0, 128'h66, 0);   step("wr0_a6",     2'b01, -1, 0);
      drive(2'b01, 2'b00, 3, 0, 0, 0);         step("rd0_dropped", 2'b01, -1, 0);
      rst = 1'b1;
      drive(2'b00, 2'b00, 0, 0, 0, 0);         step("mid_reset",  2'b00, -1, 0);
      rst = 1'b0;
      drive(2'b11, 2'b00, 3, 6, 0, 0);         step("post_rst_rd", 2'b01, 0, 128'h10);
      drive(2'b10, 2'b00, 3, 6, 0, 0);         step("rd1_a6",     2'b10, 1, 128'h66);
      drive(2'b11, 2'b11, 4, 4, 128'h44, 128'h45); step("post_rst_wr", 2'b01, -1, 0);
      drive(2'b10, 2'b10, 4, 4, 128'h44, 128'h45); step("wr1_a4",  2'b10, -1, 0);
      drive(2'b01, 2'b00, 4, 0, 0, 0);         step("rd0_a4",     2'b01, 0, 128'h45);
      drive(2'b00, 2'b00, 0, 0, 0, 0);         step("idle",       2'b00, -1, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Shares one `BRAM_inst` simple dual-port RAM (one write port, one read port) between `NUM_REQ` requesters inside the OT accelerator datapath. Each port has its own round-robin arbiter, so a write from one requester and a read from another complete in the same cycle. The block owns the RAM instance and returns read data to the granted requester with fixed one-cycle latency.

## Interface
- `DATA_WIDTH`, 128, RAM word width
- `ADDR_WIDTH`, 3, RAM address width (depth 2**ADDR_WIDTH)
- `NUM_REQ`, 2, number of requesters (2..8)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_ready`  out  NUM_REQ  grant; transfer when valid & ready
- `rsp_valid`  out  NUM_REQ  read data valid for requester i
- `rsp_rdata`  out  DATA_WIDTH  read data (shared bus, qualify with rsp_valid)

## Operation
- Write port: candidates = `req_valid & req_we`. Read port: candidates = `req_valid & ~req_we`. Each port runs an independent round-robin arbiter.
- Round-robin: search starts at the port's pointer `ptr` and wraps modulo NUM_REQ; first candidate wins. After a grant to i, `ptr <= (i+1) % NUM_REQ`. With no grant, `ptr` holds.
- At most one write and one read grant per cycle; `req_ready` is the OR of both one-hot grants.
- `req_ready` is combinational from `req_valid`/pointers; no combinational path from `req_ready` back into `req_valid` is permitted. Requesters hold valid, we, addr, wdata stable until ready.
- Write grant: `wr_en=1`, `write_addr`/`data_in` from the winner, same cycle.
- Read grant: `read_addr` from winner; winner id registered in `rd_owner`, `rd_pend <= 1`.
- Response: cycle after read grant, `rsp_valid[rd_owner]=1`, `rsp_rdata=data_out`. Back-to-back reads are allowed each cycle (fully pipelined, no backpressure on responses).
- Same-cycle read and write to the same address: read returns the newly written data (registered read address).
- Idle: `wr_en=0`; `read_addr` holds the last value.

## Timing
- Reset values: `req_ready=0` while `rst=1`; `rsp_valid=0`; both `ptr=0`; `rd_pend=0`; `rsp_rdata` follows `data_out` (don't-care while `rsp_valid=0`).
- Write latency: data is in the RAM after the grant edge.
- Read latency: exactly 1 cycle from grant to `rsp_valid`.
- Reset asserted mid-operation: an in-flight read response is dropped (`rsp_valid=0` next cycle). RAM contents are not cleared.

## Configuration
- `BRAM_ARB_STATS_EN` defined: adds outputs `stat_wr_grants` and `stat_rd_grants` (each NUM_REQ*32, per-requester grant counts) and `stat_conflicts` (32, cycles where any port had more than one candidate). All counters clear on `rst` and wrap at 2**32.
- Undefined: these ports and counters are absent.

## Structure
- Package `bram_arb_pkg`: `NUM_REQ_MAX=8`, `req_id_t` (logic [2:0]), `STAT_W=32`.
- Sub-module `rr_arb` (params NUM_REQ; in `clk`, `rst`, `cand`; out one-hot `grant`, `grant_id`, `grant_any`). Instantiated twice (write, read) alongside one `BRAM_inst`.

## Test plan
- Reset, then requester 0 writes addr 3 = 0x10, then reads addr 3 -> one cycle after read grant, `rsp_valid=2'b01`, `rsp_rdata=0x10`.
- Both requesters read continuously (addrs 1 and 2 preloaded 0xA/0xB) -> grants alternate 0,1,0,1; responses alternate 0xA/0xB, one per cycle.
- Requester 0 writes addr 5 = 0x55 while requester 1 reads addr 5 in the same cycle -> both ready=1; response to 1 is 0x55.
- Both write together (addr 0 = 0x1, addr 0 = 0x2) -> requester 0 wins first, requester 1 next cycle; subsequent read of addr 0 returns 0x2.
- Assert `rst` the cycle after a read grant -> `rsp_valid` stays 0, `ptr` returns to 0, and the RAM retains earlier writes.
- With `BRAM_ARB_STATS_EN`: 4 contested reads -> `stat_rd_grants` = 2/2, `stat_conflicts` = 3 (one requester is uncontested on the last cycle).
